// File: rtl/comb_prog_truth_tbl_pkg.sv
// Shared types and default sizing for the programmable truth-table evaluator.
package comb_prog_truth_tbl_pkg;

  // Default geometry: 4-input functions, two channels.
  localparam int LP_NINPUTS = 4;
  localparam int LP_NCHANS  = 2;

  // Table width and channel-select width for the default geometry.
  localparam int T = 1 << LP_NINPUTS;
  localparam int C = $clog2(LP_NCHANS);

  // Table loaded into every channel at reset; bit i is f(inputs == i).
  localparam logic [T-1:0] DEF_TBL = 16'hA533;

  // Configuration sequencer states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    COMMIT = 2'd2
  } cfg_state_e;

  // True when a channel number addresses an existing table.
  function automatic logic chan_in_range(input int chan, input int nchans);
    return (chan >= 0) && (chan < nchans);
  endfunction

endpackage

// File: rtl/comb_prog_truth_tbl_cfg_fsm.sv
// Serial table loader: collects table bits LSB first into a shadow register
// and presents the finished table for a single-cycle commit.
//
//   state  | meaning
//   -------+------------------------------------------------------------
//   IDLE   | waiting for i_cfg_start; stray i_cfg_bit_val is ignored
//   LOAD   | shifting bits into shadow[cnt]; last bit (cnt==T-1) -> COMMIT
//   COMMIT | shadow is written into the table array at the closing edge
module comb_prog_truth_tbl_cfg_fsm
  import comb_prog_truth_tbl_pkg::*;
#(
  parameter int P_TBL_W  = T,
  parameter int P_CHAN_W = C
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_cfg_start,
  input  logic [P_CHAN_W-1:0] i_cfg_chan,
  input  logic                i_cfg_bit_val,
  input  logic                i_cfg_bit,
  output logic                o_cfg_busy,
  output logic                o_cfg_done,
  output logic                o_commit_en,
  output logic [P_CHAN_W-1:0] o_commit_chan,
  output logic [P_TBL_W-1:0]  o_commit_tbl
);

  localparam int CW = $clog2(P_TBL_W);
  localparam logic [CW-1:0] LP_LAST = CW'(P_TBL_W - 1);

  cfg_state_e          r_state;
  logic [CW-1:0]       r_cnt;
  logic [P_TBL_W-1:0]  r_shadow;
  logic [P_CHAN_W-1:0] r_chan;
  logic                r_busy;
  logic                r_done;

  // Sequencer, bit counter and shadow register; busy/done are registered so
  // they line up with the table write that happens at the end of COMMIT.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_shadow <= '0;
      r_chan   <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_cfg_start) begin
            r_state  <= LOAD;
            r_chan   <= i_cfg_chan;
            r_shadow <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b1;
          end
        end
        LOAD: begin
          if (i_cfg_bit_val) begin
            r_shadow[r_cnt] <= i_cfg_bit;
            r_cnt           <= r_cnt + CW'(1);
            if (r_cnt == LP_LAST) begin
              r_state <= COMMIT;
            end
          end
        end
        COMMIT: begin
          // Table write happens at this same edge, so done and the new
          // contents become visible together.
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_cnt   <= '0;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_cfg_busy    = r_busy;
  assign o_cfg_done    = r_done;
  assign o_commit_en   = (r_state == COMMIT);
  assign o_commit_chan = r_chan;
  assign o_commit_tbl  = r_shadow;

endmodule

// File: rtl/comb_prog_truth_tbl_seq.sv
// Multi-channel programmable truth-table evaluator: committed tables plus a
// one-entry registered query pipeline with val/rdy handshakes.
module comb_prog_truth_tbl_seq
  import comb_prog_truth_tbl_pkg::*;
#(
  parameter int                           P_NINPUTS   = LP_NINPUTS,
  parameter int                           P_NCHANS    = LP_NCHANS,
  parameter logic [(1<<P_NINPUTS)-1:0]    P_RESET_TBL = DEF_TBL
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         cfg_start,
  input  logic [$clog2(P_NCHANS)-1:0]  cfg_chan,
  input  logic                         cfg_bit_val,
  input  logic                         cfg_bit,
  output logic                         cfg_busy,
  output logic                         cfg_done,
  input  logic                         in_val,
  output logic                         in_rdy,
  input  logic [$clog2(P_NCHANS)-1:0]  in_chan,
  input  logic [P_NINPUTS-1:0]         in_bits,
  output logic                         out_val,
  input  logic                         out_rdy,
  output logic [$clog2(P_NCHANS)-1:0]  out_chan,
  output logic                         out_f
);

  localparam int LP_T = 1 << P_NINPUTS;
  localparam int LP_C = $clog2(P_NCHANS);

  logic [LP_T-1:0] r_tbl [P_NCHANS];

  logic            r_out_val;
  logic [LP_C-1:0] r_out_chan;
  logic            r_out_f;

  logic            w_commit_en;
  logic [LP_C-1:0] w_commit_chan;
  logic [LP_T-1:0] w_commit_tbl;
  logic            w_commit_ok;
  logic            w_in_chan_ok;
  logic [LP_T-1:0] w_rd_tbl;
  logic            w_rd_f;
  logic            w_accept;

  comb_prog_truth_tbl_cfg_fsm #(
    .P_TBL_W  (LP_T),
    .P_CHAN_W (LP_C)
  ) u_cfg_fsm (
    .clk           (clk),
    .reset         (reset),
    .i_cfg_start   (cfg_start),
    .i_cfg_chan    (cfg_chan),
    .i_cfg_bit_val (cfg_bit_val),
    .i_cfg_bit     (cfg_bit),
    .o_cfg_busy    (cfg_busy),
    .o_cfg_done    (cfg_done),
    .o_commit_en   (w_commit_en),
    .o_commit_chan (w_commit_chan),
    .o_commit_tbl  (w_commit_tbl)
  );

  // A load aimed at a missing channel still runs to completion but is dropped.
  assign w_commit_ok  = chan_in_range(int'(w_commit_chan), P_NCHANS);
  assign w_in_chan_ok = chan_in_range(int'(in_chan), P_NCHANS);

  // Committed table storage; the whole word is replaced in one edge so a
  // query never observes a partial table.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < P_NCHANS; k++) begin
        r_tbl[k] <= P_RESET_TBL;
      end
    end else if (w_commit_en && w_commit_ok) begin
      r_tbl[w_commit_chan] <= w_commit_tbl;
    end
  end

  // Lookup uses the table value before any same-edge commit (old table wins).
  assign w_rd_tbl = w_in_chan_ok ? r_tbl[in_chan] : '0;
  assign w_rd_f   = w_rd_tbl[in_bits];

  assign in_rdy   = !r_out_val || out_rdy;
  assign w_accept = in_val && in_rdy;

  // One-entry output register; holds its contents while the consumer stalls.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_val  <= 1'b0;
      r_out_chan <= '0;
      r_out_f    <= 1'b0;
    end else if (w_accept) begin
      r_out_val  <= 1'b1;
      r_out_chan <= in_chan;
      r_out_f    <= w_rd_f;
    end else if (r_out_val && out_rdy) begin
      r_out_val  <= 1'b0;
    end
  end

  assign out_val  = r_out_val;
  assign out_chan = r_out_chan;
  assign out_f    = r_out_f;

endmodule

// File: tb/tb_comb_prog_truth_tbl_seq.sv
// Directed bench for the programmable truth-table evaluator.
module tb_comb_prog_truth_tbl_seq;
  import comb_prog_truth_tbl_pkg::*;

  logic         clk = 1'b0;
  logic         reset;
  logic         cfg_start;
  logic [C-1:0] cfg_chan;
  logic         cfg_bit_val;
  logic         cfg_bit;
  logic         cfg_busy;
  logic         cfg_done;
  logic         in_val;
  logic         in_rdy;
  logic [C-1:0] in_chan;
  logic [3:0]   in_bits;
  logic         out_val;
  logic         out_rdy;
  logic [C-1:0] out_chan;
  logic         out_f;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  comb_prog_truth_tbl_seq dut (
    .clk         (clk),
    .reset       (reset),
    .cfg_start   (cfg_start),
    .cfg_chan    (cfg_chan),
    .cfg_bit_val (cfg_bit_val),
    .cfg_bit     (cfg_bit),
    .cfg_busy    (cfg_busy),
    .cfg_done    (cfg_done),
    .in_val      (in_val),
    .in_rdy      (in_rdy),
    .in_chan     (in_chan),
    .in_bits     (in_bits),
    .out_val     (out_val),
    .out_rdy     (out_rdy),
    .out_chan    (out_chan),
    .out_f       (out_f)
  );

  task automatic chk_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic query(input logic [C-1:0] ch, input logic [3:0] bits, input logic exp, input string tag);
    in_val  = 1'b1;
    in_chan = ch;
    in_bits = bits;
    out_rdy = 1'b1;
    tick;
    in_val = 1'b0;
    chk_val({tag, "_val"}, 32'(out_val), 32'd1);
    chk_val({tag, "_chan"}, 32'(out_chan), 32'(ch));
    chk_val({tag, "_f"}, 32'(out_f), 32'(exp));
  endtask

  task automatic read_tbl(input logic [C-1:0] ch, output logic [15:0] w);
    w       = '0;
    out_rdy = 1'b1;
    in_val  = 1'b1;
    in_chan = ch;
    for (int i = 0; i < 16; i++) begin
      in_bits = 4'(i);
      tick;
      w[i] = out_f;
    end
    in_val = 1'b0;
  endtask

  // Starts a load and streams 16 bits; returns in the COMMIT cycle with the
  // cycle number counted from cfg_start (cycle 0).
  task automatic load_bits(input logic [C-1:0] ch, input logic [15:0] v, input bit gap,
                           input bit restart, output int cyc, output bit early);
    int nb;
    bit vld;
    early     = 1'b0;
    nb        = 0;
    cfg_chan  = ch;
    cfg_start = 1'b1;
    tick;
    cfg_start = 1'b0;
    cyc       = 1;
    while (nb < 16) begin
      vld         = !gap || (cyc % 2 == 1);
      cfg_start   = restart && (cyc == 5);
      cfg_chan    = (restart && cyc == 5) ? ~ch : ch;
      cfg_bit_val = vld;
      cfg_bit     = v[nb];
      if (cfg_done) early = 1'b1;
      tick;
      if (vld) nb++;
      cyc++;
    end
    cfg_start   = 1'b0;
    cfg_chan    = ch;
    cfg_bit_val = 1'b0;
    cfg_bit     = 1'b0;
  endtask

  task automatic wait_done(input int cyc0, output int done_cyc);
    int c;
    c        = cyc0;
    done_cyc = -1;
    for (int k = 0; k < 40; k++) begin
      if (cfg_done) begin
        done_cyc = c;
        break;
      end
      tick;
      c++;
    end
  endtask

  initial begin
    int          cyc;
    int          dcyc;
    bit          early;
    logic [15:0] w;
    logic        exp_sweep [16] = '{1,1,0,0, 1,1,0,0, 1,0,1,0, 0,1,0,1};

    reset       = 1'b1;
    cfg_start   = 1'b0;
    cfg_chan    = '0;
    cfg_bit_val = 1'b0;
    cfg_bit     = 1'b0;
    in_val      = 1'b0;
    in_chan     = '0;
    in_bits     = '0;
    out_rdy     = 1'b1;
    repeat (3) tick;
    reset = 1'b0;

    chk_val("rst_busy", 32'(cfg_busy), 32'd0);
    chk_val("rst_done", 32'(cfg_done), 32'd0);
    chk_val("rst_out_val", 32'(out_val), 32'd0);
    chk_val("rst_out_chan", 32'(out_chan), 32'd0);
    chk_val("rst_out_f", 32'(out_f), 32'd0);
    chk_val("rst_in_rdy", 32'(in_rdy), 32'd1);

    // Reset-table sweep on ch0, one result per cycle.
    in_val  = 1'b1;
    in_chan = '0;
    for (int i = 0; i < 16; i++) begin
      in_bits = 4'(i);
      tick;
      chk_val($sformatf("sweep_val_%0d", i), 32'(out_val), 32'd1);
      chk_val($sformatf("sweep_f_%0d", i), 32'(out_f), 32'(exp_sweep[i]));
    end
    in_val = 1'b0;
    tick;
    chk_val("sweep_drain", 32'(out_val), 32'd0);

    // Commit race: ch1 still holds A533 (bit0=1); new table FFFE has bit0=0.
    load_bits(1'b1, 16'hFFFE, 1'b0, 1'b0, cyc, early);
    chk_val("race_busy_commit", 32'(cfg_busy), 32'd1);
    in_val  = 1'b1;
    in_chan = 1'b1;
    in_bits = 4'd0;
    out_rdy = 1'b1;
    tick;
    chk_val("race_done", 32'(cfg_done), 32'd1);
    chk_val("race_old_f", 32'(out_f), 32'd1);
    tick;
    chk_val("race_new_f", 32'(out_f), 32'd0);
    in_val = 1'b0;
    tick;

    // Load ch1 = 8000.
    load_bits(1'b1, 16'h8000, 1'b0, 1'b0, cyc, early);
    wait_done(cyc, dcyc);
    chk_val("load_done_cyc", 32'(dcyc), 32'd18);
    chk_val("load_no_early", 32'(early), 32'd0);
    tick;
    chk_val("load_done_pulse", 32'(cfg_done), 32'd0);
    chk_val("load_busy_end", 32'(cfg_busy), 32'd0);
    query(1'b1, 4'd15, 1'b1, "ch1_b15");
    query(1'b1, 4'd14, 1'b0, "ch1_b14");
    read_tbl(1'b0, w);
    chk_val("ch0_unchanged", 32'(w), 32'h0000A533);

    // Back-pressure: held result ch0/f=1, pending ch1 bits14 -> f=0.
    tick;
    query(1'b0, 4'd0, 1'b1, "bp_first");
    in_val  = 1'b1;
    in_chan = 1'b1;
    in_bits = 4'd14;
    out_rdy = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk_val($sformatf("bp_in_rdy_%0d", k), 32'(in_rdy), 32'd0);
      chk_val($sformatf("bp_hold_f_%0d", k), 32'(out_f), 32'd1);
      chk_val($sformatf("bp_hold_chan_%0d", k), 32'(out_chan), 32'd0);
      chk_val($sformatf("bp_hold_val_%0d", k), 32'(out_val), 32'd1);
      tick;
    end
    chk_val("bp_still_held", 32'(out_chan), 32'd0);
    out_rdy = 1'b1;
    #1;
    chk_val("bp_release_rdy", 32'(in_rdy), 32'd1);
    tick;
    in_val = 1'b0;
    chk_val("bp_next_val", 32'(out_val), 32'd1);
    chk_val("bp_next_chan", 32'(out_chan), 32'd1);
    chk_val("bp_next_f", 32'(out_f), 32'd0);
    tick;
    chk_val("bp_no_dup", 32'(out_val), 32'd0);

    // Gapped load of ch1 = 1234 with a stray cfg_start (ch0) mid-load.
    load_bits(1'b1, 16'h1234, 1'b1, 1'b1, cyc, early);
    wait_done(cyc, dcyc);
    chk_val("gap_done_cyc", 32'(dcyc), 32'd33);
    chk_val("gap_no_early", 32'(early), 32'd0);
    tick;
    query(1'b1, 4'd2, 1'b1, "gap_ch1_b2");
    query(1'b1, 4'd0, 1'b0, "gap_ch1_b0");
    query(1'b1, 4'd12, 1'b1, "gap_ch1_b12");
    query(1'b1, 4'd13, 1'b0, "gap_ch1_b13");
    query(1'b0, 4'd0, 1'b1, "gap_ch0_b0");
    query(1'b0, 4'd2, 1'b0, "gap_ch0_b2");
    tick;

    // Reset at bit 7 of a load with a result stalled in the output register.
    cfg_chan  = 1'b0;
    cfg_start = 1'b1;
    tick;
    cfg_start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      cfg_bit_val = 1'b1;
      cfg_bit     = 1'b0;
      if (i == 6) begin
        in_val  = 1'b1;
        in_chan = 1'b1;
        in_bits = 4'd0;
        out_rdy = 1'b0;
      end
      tick;
    end
    in_val = 1'b0;
    chk_val("mid_busy", 32'(cfg_busy), 32'd1);
    chk_val("mid_out_val", 32'(out_val), 32'd1);
    reset = 1'b1;
    tick;
    reset       = 1'b0;
    cfg_bit_val = 1'b0;
    chk_val("mid_rst_busy", 32'(cfg_busy), 32'd0);
    chk_val("mid_rst_out_val", 32'(out_val), 32'd0);
    repeat (20) begin
      if (cfg_done) begin
        chk_val("mid_rst_no_done", 32'(cfg_done), 32'd0);
      end
      tick;
    end
    chk_val("mid_rst_idle_busy", 32'(cfg_busy), 32'd0);
    read_tbl(1'b0, w);
    chk_val("mid_rst_ch0", 32'(w), 32'h0000A533);
    read_tbl(1'b1, w);
    chk_val("mid_rst_ch1", 32'(w), 32'h0000A533);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_chk);
    $fatal(1, "watchdog expired");
  end

endmodule
